// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM stage: opcodes, decoder instruction ids, MEM state encoding.
// Helper functions classify ids by access kind and flag misaligned addresses.
package mem_access_unit_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [5:0] INSTR_LB  = 6'd16;
    localparam logic [5:0] INSTR_LH  = 6'd17;
    localparam logic [5:0] INSTR_LW  = 6'd18;
    localparam logic [5:0] INSTR_LBU = 6'd19;
    localparam logic [5:0] INSTR_LHU = 6'd20;
    localparam logic [5:0] INSTR_SB  = 6'd21;
    localparam logic [5:0] INSTR_SH  = 6'd22;
    localparam logic [5:0] INSTR_SW  = 6'd23;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    function automatic logic is_load_id(input logic [5:0] id);
        return id inside {INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU};
    endfunction

    function automatic logic is_store_id(input logic [5:0] id);
        return id inside {INSTR_SB, INSTR_SH, INSTR_SW};
    endfunction

    function automatic logic is_misaligned(input logic [5:0] id, input logic [1:0] lo);
        if (id inside {INSTR_LH, INSTR_LHU, INSTR_SH}) return lo[0];
        if (id inside {INSTR_LW, INSTR_SW})            return lo != 2'b00;
        return 1'b0;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// EX/MEM input, data-memory port and MEM/WB output bundle of the MEM stage.
// slave = the MEM stage itself, master = its environment (EX, memory, WB).
interface mem_access_unit_if;
    logic        in_valid;
    logic [6:0]  in_opcode;
    logic [5:0]  in_instr_id;
    logic [4:0]  in_rd_addr;
    logic        in_rd_we;
    logic [31:0] in_mem_addr;
    logic [31:0] in_store_data;
    logic [31:0] in_exec_result;
    logic        stall_o;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_we;
    logic [31:0] wb_data;
    logic        misalign_o;
    logic        bus_fault_o;

    modport slave (
        input  in_valid, in_opcode, in_instr_id, in_rd_addr, in_rd_we,
               in_mem_addr, in_store_data, in_exec_result, dmem_ack, dmem_rdata,
        output stall_o, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, wb_rd_addr, wb_rd_we, wb_data, misalign_o, bus_fault_o
    );

    modport master (
        output in_valid, in_opcode, in_instr_id, in_rd_addr, in_rd_we,
               in_mem_addr, in_store_data, in_exec_result, dmem_ack, dmem_rdata,
        input  stall_o, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, wb_rd_addr, wb_rd_we, wb_data, misalign_o, bus_fault_o
    );
endinterface

// File: rtl/mem_access_unit_load_store_align.sv
// Combinational byte-lane logic: store data replication + strobes, load extract + extension.
// Zero latency; no flow control. Store and load paths are independent.
module load_store_align
    import mem_access_unit_pkg::*;
(
    input  logic [5:0]  st_id_i,
    input  logic [1:0]  st_lo_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wstrb_o,
    input  logic [5:0]  ld_id_i,
    input  logic [1:0]  ld_lo_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata_o = st_data_i;
        st_wstrb_o = 4'b1111;
        case (st_id_i)
            INSTR_SB: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_wstrb_o = 4'b0001 << st_lo_i;
            end
            INSTR_SH: begin
                st_wdata_o = {2{st_data_i[15:0]}};
                st_wstrb_o = st_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte   = ld_rdata_i[{ld_lo_i, 3'b000} +: 8];
        ld_half   = ld_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        ld_data_o = ld_rdata_i;
        case (ld_id_i)
            INSTR_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            INSTR_LBU: ld_data_o = {24'h0, ld_byte};
            INSTR_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            INSTR_LHU: ld_data_o = {16'h0, ld_half};
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: non-memory ops retire in 1 cycle; loads/stores hold the bus until ack or timeout.
// stall_o holds upstream while an access is outstanding and drops on the ack cycle.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);
    localparam int unsigned   CW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [5:0]    id_q, id_d;
    logic [1:0]    lo_q, lo_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    logic          rd_we_q, rd_we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          wb_valid_q, wb_valid_d;
    logic [4:0]    wb_rd_addr_q, wb_rd_addr_d;
    logic          wb_rd_we_q, wb_rd_we_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          misalign_q, misalign_d;
    logic          fault_q, fault_d;

    logic [31:0]   st_wdata, ld_data;
    logic [3:0]    st_wstrb;
    logic          in_mem_opc, in_mem_op, in_is_store;

    load_store_align u_align (
        .st_id_i    (bus.in_instr_id),
        .st_lo_i    (bus.in_mem_addr[1:0]),
        .st_data_i  (bus.in_store_data),
        .st_wdata_o (st_wdata),
        .st_wstrb_o (st_wstrb),
        .ld_id_i    (id_q),
        .ld_lo_i    (lo_q),
        .ld_rdata_i (bus.dmem_rdata),
        .ld_data_o  (ld_data)
    );

    assign in_is_store = (bus.in_opcode == OP_STORE);
    assign in_mem_opc  = (bus.in_opcode == OP_LOAD) || in_is_store;
    // A memory opcode only starts an access when the id agrees with it.
    assign in_mem_op   = ((bus.in_opcode == OP_LOAD) && is_load_id(bus.in_instr_id)) ||
                         (in_is_store && is_store_id(bus.in_instr_id));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        id_d         = id_q;
        lo_d         = lo_q;
        rd_addr_d    = rd_addr_q;
        rd_we_d      = rd_we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wb_valid_d   = 1'b0;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_rd_we_d   = wb_rd_we_q;
        wb_data_d    = wb_data_q;
        misalign_d   = 1'b0;
        fault_d      = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (bus.in_valid) begin
                    if (!in_mem_op) begin
                        wb_valid_d   = 1'b1;
                        wb_rd_addr_d = bus.in_rd_addr;
                        wb_rd_we_d   = bus.in_rd_we && !in_mem_opc;
                        wb_data_d    = bus.in_exec_result;
                    end else if (is_misaligned(bus.in_instr_id, bus.in_mem_addr[1:0])) begin
                        wb_valid_d   = 1'b1;
                        wb_rd_addr_d = bus.in_rd_addr;
                        wb_rd_we_d   = 1'b0;
                        wb_data_d    = 32'h0;
                        misalign_d   = 1'b1;
                    end else begin
                        state_d   = MEM_BUSY;
                        cnt_d     = '0;
                        we_d      = in_is_store;
                        id_d      = bus.in_instr_id;
                        lo_d      = bus.in_mem_addr[1:0];
                        rd_addr_d = bus.in_rd_addr;
                        rd_we_d   = bus.in_rd_we;
                        addr_d    = {bus.in_mem_addr[31:2], 2'b00};
                        wdata_d   = st_wdata;
                        wstrb_d   = in_is_store ? st_wstrb : 4'b0000;
                    end
                end
            end
            MEM_BUSY: begin
                if (bus.dmem_ack) begin
                    state_d      = MEM_IDLE;
                    wb_valid_d   = 1'b1;
                    wb_rd_addr_d = rd_addr_q;
                    wb_rd_we_d   = !we_q && rd_we_q;
                    wb_data_d    = we_q ? 32'h0 : ld_data;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d      = MEM_IDLE;
                    wb_valid_d   = 1'b1;
                    wb_rd_addr_d = rd_addr_q;
                    wb_rd_we_d   = 1'b0;
                    wb_data_d    = 32'h0;
                    fault_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= MEM_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            id_q         <= '0;
            lo_q         <= '0;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_rd_we_q   <= 1'b0;
            wb_data_q    <= '0;
            misalign_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            id_q         <= id_d;
            lo_q         <= lo_d;
            rd_addr_q    <= rd_addr_d;
            rd_we_q      <= rd_we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_rd_we_q   <= wb_rd_we_d;
            wb_data_q    <= wb_data_d;
            misalign_q   <= misalign_d;
            fault_q      <= fault_d;
        end
    end

    // Request follows the state register so an async reset withdraws it at once.
    assign bus.dmem_req    = (state_q == MEM_BUSY);
    assign bus.stall_o     = (state_q == MEM_BUSY) && !bus.dmem_ack;
    assign bus.dmem_we     = we_q;
    assign bus.dmem_addr   = addr_q;
    assign bus.dmem_wdata  = wdata_q;
    assign bus.dmem_wstrb  = wstrb_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd_addr  = wb_rd_addr_q;
    assign bus.wb_rd_we    = wb_rd_we_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.misalign_o  = misalign_q;
    assign bus.bus_fault_o = fault_q;
endmodule
